mc_core: RTL and testbench
==========================

MC_CORE -- requirements
Module: mc_core

Interface
REQ-001 SHALL have parameter ADDR_W, 16, memory address width; pc and mem_addr are ADDR_W bits.
REQ-002 SHALL have parameter NREGS, 16, register count, power of 2 in 2..16.
REQ-003 SHALL have parameter RESET_PC, 0, pc value loaded on reset.
REQ-004 SHALL have port clk  in  1  clock, all state changes on rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mem_req  out  1  memory request, held high until mem_ack.
REQ-007 SHALL have port mem_we  out  1  1=store, 0=read; valid while mem_req.
REQ-008 SHALL have port mem_ispace  out  1  1=instruction fetch, 0=data access.
REQ-009 SHALL have port mem_addr  out  ADDR_W  access address; stable while mem_req.
REQ-010 SHALL have port mem_wdata  out  16  store data.
REQ-011 SHALL have port mem_rdata  in  16  read data, sampled in the cycle mem_ack=1.
REQ-012 SHALL have port mem_ack  in  1  access complete; ignored while mem_req=0.
REQ-013 SHALL have port halt  out  1  core stopped.
REQ-014 SHALL have port halt_code  out  8  trap code, or 8'hFF on illegal instruction.
REQ-015 SHALL have port retired  out  32  count of completed non-halting instructions, wraps at 2^32.

Function
REQ-016 SHALL use states FETCH, DECODE, EXEC, MEM, HALT with fixed transitions: FETCH -ack-> DECODE -> EXEC -> (MEM if ld/st, HALT if trap/illegal, else FETCH); MEM -ack-> FETCH; HALT is terminal.
REQ-017 FETCH SHALL drive mem_req=1, mem_we=0, mem_ispace=1, mem_addr=pc, and latch ir on ack; ack may arrive in the first request cycle or after any number of wait cycles.
REQ-018 DECODE SHALL set pc <= pc+1 modulo 2^ADDR_W.
REQ-019 Fields SHALL be op0=ir[15:12], op1=ir[11:8], ra=ir[3:0] (destination/test), rb=ir[7:4] (source), imm8=ir[11:4].
REQ-020 op0=0: op1=0 trap (halt_code<=ir[7:0]); op1=1 jr (pc<=r[ra][ADDR_W-1:0], zero-extended if ADDR_W>16).
REQ-021 op0=5: op1 0/1/2/3 SHALL compute r[ra]<= r[ra]&r[rb] / r[ra]|r[rb] / r[ra]^r[rb] / ~r[ra].
REQ-022 op0=7: op1 0/1/2 SHALL compute r[ra]<= r[ra]+r[rb] / r[ra]-r[rb] / -r[ra], all modulo 2^16, no flags.
REQ-023 op0=4: op1=0 load r[ra]<=mem[r[rb]]; op1=1 store mem[r[rb]]<=r[ra]; MEM drives mem_ispace=0, mem_addr=r[rb] truncated/zero-extended to ADDR_W.
REQ-024 op0=B: r[ra] <= sign-extended imm8.
REQ-025 op0=E (bz) / F (bnz): if r[ra]==0 (bz) or !=0 (bnz), pc <= incremented pc + sext(imm8), modulo 2^ADDR_W; else pc unchanged.
REQ-026 Any other op0/op1 combination, or ra/rb >= NREGS for a field the instruction uses, SHALL be illegal: no register/memory side effect, halt_code<=8'hFF, enter HALT.
REQ-027 Entering HALT SHALL set halt=1 one cycle after EXEC; halt, halt_code, pc, registers then hold until reset; mem_req=0 in HALT.
REQ-028 retired SHALL increment by 1 on the FETCH-entry edge after each completed instruction (EXEC->FETCH or MEM->FETCH); trap and illegal SHALL NOT increment.
REQ-029 Minimum latency SHALL be 3 cycles for non-memory instructions and 4 for ld/st with zero-wait acks.
REQ-030 Store to r[rb] address and read-after-write of the same register in consecutive instructions SHALL see updated values (no forwarding hazard exists in multi-cycle sequencing).

Reset
REQ-031 reset=1 SHALL immediately force state FETCH-pending, pc=RESET_PC, all registers 0, mem_req=0, halt=0, halt_code=0, retired=0.
REQ-032 Reset during an outstanding request SHALL drop mem_req asynchronously; an ack arriving after release without a new request SHALL be ignored.
REQ-033 First fetch SHALL request on the first rising edge after reset deasserts.

Verification
REQ-034 Zero-wait ack; program ci8 r1,5; ci8 r2,-3; add r1,r2; trap 8'h2A -> r1=16'h0002, halt=1, halt_code=8'h2A, retired=3.
REQ-035 Fetch ack delayed 4 cycles -> mem_req held high with stable mem_addr for 5 cycles, then ir latched; no double execution.
REQ-036 r3=16'h0010, st r4,[r3] with r4=16'hBEEF, then ld r5,[r3] -> write cycle at addr 16'h0010 with wdata BEEF, r5=16'hBEEF.
REQ-037 bnz r0 (r0=0) then bz r0 imm8=8'hFE at pc=16'h0005 -> first not taken; second sets pc=16'h0004; ADDR_W=8 pc=8'hFF increment wraps to 8'h00.
REQ-038 NREGS=4, instruction add r5,r1 -> halt=1, halt_code=8'hFF, r1 unchanged, retired unchanged.
REQ-039 reset asserted mid-MEM with ack pending -> mem_req=0 same cycle, pc=RESET_PC, retired=0, subsequent stray ack has no effect.

Source files
------------

// File: rtl/mc_core.sv
// Multi-cycle 16-bit core: FETCH/DECODE/EXEC/MEM/HALT sequencing over a single
// request/acknowledge memory port shared by instruction and data accesses.
module mc_core #(
  parameter int ADDR_W   = 16,
  parameter int NREGS    = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_ispace,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              halt,
  output logic [7:0]        halt_code,
  output logic [31:0]       retired
);
  localparam int RI_W = (NREGS > 2) ? $clog2(NREGS) : 1;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_regs [NREGS];
  logic              r_mem_req;
  logic              r_halt;
  logic [7:0]        r_halt_code;
  logic [31:0]       r_retired;

  logic [3:0]        w_op0, w_op1, w_ra, w_rb;
  logic [7:0]        w_imm8;
  logic [RI_W-1:0]   w_ra_idx, w_rb_idx;
  logic [15:0]       w_rav, w_rbv;
  logic              w_legal, w_use_ra, w_use_rb, w_wr, w_pc_ld, w_is_mem, w_is_trap;
  logic              w_illegal;
  logic [15:0]       w_wr_val;
  logic [ADDR_W-1:0] w_pc_val;

  function automatic logic reg_ok(input logic [3:0] idx);
    return ({28'd0, idx} < 32'(NREGS));
  endfunction

  assign w_op0    = r_ir[15:12];
  assign w_op1    = r_ir[11:8];
  assign w_rb     = r_ir[7:4];
  assign w_ra     = r_ir[3:0];
  assign w_imm8   = r_ir[11:4];
  assign w_ra_idx = w_ra[RI_W-1:0];
  assign w_rb_idx = w_rb[RI_W-1:0];
  assign w_rav    = r_regs[w_ra_idx];
  assign w_rbv    = r_regs[w_rb_idx];

  always_comb begin
    w_legal   = 1'b0;
    w_use_ra  = 1'b0;
    w_use_rb  = 1'b0;
    w_wr      = 1'b0;
    w_wr_val  = w_rav;
    w_pc_ld   = 1'b0;
    w_pc_val  = r_pc;
    w_is_mem  = 1'b0;
    w_is_trap = 1'b0;
    case (w_op0)
      4'h0: begin
        if (w_op1 == 4'h0) begin
          w_legal   = 1'b1;
          w_is_trap = 1'b1;
        end else if (w_op1 == 4'h1) begin
          w_legal  = 1'b1;
          w_use_ra = 1'b1;
          w_pc_ld  = 1'b1;
          w_pc_val = ADDR_W'(w_rav);
        end
      end
      4'h4: begin
        w_legal  = (w_op1 <= 4'h1);
        w_use_ra = 1'b1;
        w_use_rb = 1'b1;
        w_is_mem = 1'b1;
      end
      4'h5: begin
        case (w_op1)
          4'h0: begin w_legal = 1'b1; w_use_rb = 1'b1; w_wr_val = w_rav & w_rbv; end
          4'h1: begin w_legal = 1'b1; w_use_rb = 1'b1; w_wr_val = w_rav | w_rbv; end
          4'h2: begin w_legal = 1'b1; w_use_rb = 1'b1; w_wr_val = w_rav ^ w_rbv; end
          4'h3: begin w_legal = 1'b1; w_wr_val = ~w_rav; end
          default: ;
        endcase
        w_use_ra = 1'b1;
        w_wr     = w_legal;
      end
      4'h7: begin
        case (w_op1)
          4'h0: begin w_legal = 1'b1; w_use_rb = 1'b1; w_wr_val = w_rav + w_rbv; end
          4'h1: begin w_legal = 1'b1; w_use_rb = 1'b1; w_wr_val = w_rav - w_rbv; end
          4'h2: begin w_legal = 1'b1; w_wr_val = 16'd0 - w_rav; end
          default: ;
        endcase
        w_use_ra = 1'b1;
        w_wr     = w_legal;
      end
      4'hB: begin
        w_legal  = 1'b1;
        w_use_ra = 1'b1;
        w_wr     = 1'b1;
        w_wr_val = {{8{w_imm8[7]}}, w_imm8};
      end
      4'hE, 4'hF: begin
        // pc already holds the incremented value when EXEC evaluates the branch
        w_legal  = 1'b1;
        w_use_ra = 1'b1;
        w_pc_ld  = ((w_rav == 16'd0) == (w_op0 == 4'hE));
        w_pc_val = r_pc + ADDR_W'($signed(w_imm8));
      end
      default: ;
    endcase
  end

  assign w_illegal = !w_legal || (w_use_ra && !reg_ok(w_ra)) || (w_use_rb && !reg_ok(w_rb));

  assign mem_req    = r_mem_req;
  assign mem_we     = (r_state == S_MEM) && (w_op1 == 4'h1);
  assign mem_ispace = (r_state != S_MEM);
  assign mem_addr   = (r_state == S_MEM) ? ADDR_W'(w_rbv) : r_pc;
  assign mem_wdata  = w_rav;
  assign halt       = r_halt;
  assign halt_code  = r_halt_code;
  assign retired    = r_retired;

  // FETCH with r_mem_req low is the post-reset pending state: the request rises
  // on the first edge after release, so a stray ack before that is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= ADDR_W'(RESET_PC);
      r_ir        <= 16'd0;
      r_mem_req   <= 1'b0;
      r_halt      <= 1'b0;
      r_halt_code <= 8'd0;
      r_retired   <= 32'd0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= 16'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (!r_mem_req) begin
            r_mem_req <= 1'b1;
          end else if (mem_ack) begin
            r_ir      <= mem_rdata;
            r_mem_req <= 1'b0;
            r_state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_pc    <= r_pc + 1'b1;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (w_illegal || w_is_trap) begin
            r_halt_code <= w_illegal ? 8'hFF : r_ir[7:0];
            r_halt      <= 1'b1;
            r_state     <= S_HALT;
          end else if (w_is_mem) begin
            r_mem_req <= 1'b1;
            r_state   <= S_MEM;
          end else begin
            if (w_wr) r_regs[w_ra_idx] <= w_wr_val;
            if (w_pc_ld) r_pc <= w_pc_val;
            r_retired <= r_retired + 32'd1;
            r_mem_req <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            if (w_op1 == 4'h0) r_regs[w_ra_idx] <= mem_rdata;
            r_retired <= r_retired + 32'd1;
            r_state   <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: table of small programs run to halt, plus
// hand-written sequences for wait states, mid-access reset and a narrow core.
module tb_mc_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ispace, mem_ack, halt;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  halt_code;
  logic [31:0] retired;

  logic        reset2 = 1'b1;
  logic        mem_req2, mem_we2, mem_ispace2, mem_ack2, halt2;
  logic [7:0]  mem_addr2, halt_code2;
  logic [15:0] mem_wdata2, mem_rdata2;
  logic [31:0] retired2;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic        model_ack = 1'b0;
  logic [15:0] model_rdata = 16'h0;
  int          ack_wait = 0;
  int          wcnt = 0;
  logic        hold_data = 1'b0;
  logic        stray = 1'b0;
  logic        mem_clr = 1'b0;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = 8'h0;
  logic [15:0] pre_data = 16'h0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mc_core #(.ADDR_W(16), .NREGS(16), .RESET_PC(0)) u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ispace(mem_ispace), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halt(halt),
    .halt_code(halt_code), .retired(retired)
  );

  mc_core #(.ADDR_W(8), .NREGS(4), .RESET_PC(254)) u_dut2 (
    .clk(clk), .reset(reset2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_ispace(mem_ispace2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .halt(halt2),
    .halt_code(halt_code2), .retired(retired2)
  );

  assign mem_ack    = model_ack | stray;
  assign mem_rdata  = stray ? 16'h1000 : model_rdata;
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem_ispace2 ? imem[mem_addr2] : dmem[mem_addr2];

  // Memory responder: ack after ack_wait idle request cycles; data side can be held off.
  always @(negedge clk) begin
    if (mem_req && !(hold_data && !mem_ispace)) begin
      if (wcnt >= ack_wait) begin
        model_ack   = 1'b1;
        model_rdata = mem_ispace ? imem[mem_addr[7:0]] : dmem[mem_addr[7:0]];
        wcnt        = 0;
      end else begin
        model_ack = 1'b0;
        wcnt      = wcnt + 1;
      end
    end else begin
      model_ack = 1'b0;
      wcnt      = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) dmem[i] = 16'h0;
      if (pre_en) dmem[pre_addr] = pre_data;
    end else begin
      if (mem_req && mem_ack && mem_we) dmem[mem_addr[7:0]] = mem_wdata;
      if (mem_req2 && mem_we2) dmem[mem_addr2] = mem_wdata2;
    end
  end

  function automatic logic [15:0] ci8(input logic [3:0] ra, input logic [7:0] imm);
    return {4'hB, imm, ra};
  endfunction
  function automatic logic [15:0] rr(input logic [3:0] o0, input logic [3:0] o1,
                                     input logic [3:0] ra, input logic [3:0] rb);
    return {o0, o1, rb, ra};
  endfunction
  function automatic logic [15:0] br(input logic [3:0] o0, input logic [3:0] ra, input logic [7:0] imm);
    return {o0, imm, ra};
  endfunction
  function automatic logic [15:0] trap(input logic [7:0] c);
    return {8'h00, c};
  endfunction

  typedef struct {
    string            name;
    logic [0:7][15:0] prog;
    logic [7:0]       exp_code;
    logic [31:0]      exp_ret;
    logic             chk_en;
    logic [7:0]       chk_addr;
    logic [15:0]      chk_data;
    logic             pre;
    logic [7:0]       paddr;
    logic [15:0]      pdata;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input string nm, input logic [0:7][15:0] p, input logic [7:0] code,
                         input logic [31:0] ret, input logic ce, input logic [7:0] ca,
                         input logic [15:0] cd, input logic pe, input logic [7:0] pa,
                         input logic [15:0] pd);
    vec_t v;
    v.name = nm; v.prog = p; v.exp_code = code; v.exp_ret = ret;
    v.chk_en = ce; v.chk_addr = ca; v.chk_data = cd;
    v.pre = pe; v.paddr = pa; v.pdata = pd;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    mem_clr = 1'b1;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic wait_halt(input string nm);
    int n;
    n = 0;
    while (!halt && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_halt_reached"}, {31'd0, halt}, 32'd1);
  endtask

  task automatic load_prog(input logic [0:7][15:0] p);
    for (int i = 0; i < 256; i++) imem[i] = 16'h0;
    for (int k = 0; k < 8; k++) imem[k] = p[k];
  endtask

  initial begin
    int cnt;
    logic stable;
    int n;

    // ---- table: program, halt_code, retired, optional checked data word, optional preload
    add_vec("req034", {ci8(1,8'h05), ci8(2,8'hFD), rr(7,0,1,2), trap(8'h2A), 16'h0, 16'h0, 16'h0, 16'h0},
            8'h2A, 3, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0);
    add_vec("add_neg", {ci8(1,8'h05), ci8(2,8'hFD), rr(7,0,1,2), ci8(3,8'h40), rr(4,1,1,3), trap(8'h2A), 16'h0, 16'h0},
            8'h2A, 5, 1, 8'h40, 16'h0002, 0, 8'h00, 16'h0);
    add_vec("xor", {ci8(1,8'hF0), ci8(2,8'h3C), rr(5,2,1,2), ci8(3,8'h10), rr(4,1,1,3), trap(8'h01), 16'h0, 16'h0},
            8'h01, 5, 1, 8'h10, 16'hFFCC, 0, 8'h00, 16'h0);
    add_vec("or_not", {ci8(1,8'h3C), ci8(2,8'h0F), rr(5,1,1,2), rr(5,3,1,0), ci8(3,8'h11), rr(4,1,1,3), trap(8'h02), 16'h0},
            8'h02, 6, 1, 8'h11, 16'hFFC0, 0, 8'h00, 16'h0);
    add_vec("sub", {ci8(1,8'h05), ci8(2,8'h07), rr(7,1,1,2), ci8(3,8'h12), rr(4,1,1,3), trap(8'h03), 16'h0, 16'h0},
            8'h03, 5, 1, 8'h12, 16'hFFFE, 0, 8'h00, 16'h0);
    add_vec("neg_add", {ci8(1,8'h80), rr(7,2,1,0), rr(7,0,1,1), ci8(3,8'h13), rr(4,1,1,3), trap(8'h04), 16'h0, 16'h0},
            8'h04, 5, 1, 8'h13, 16'h0100, 0, 8'h00, 16'h0);
    add_vec("and", {ci8(1,8'h3C), ci8(2,8'h0F), rr(5,0,1,2), ci8(3,8'h14), rr(4,1,1,3), trap(8'h05), 16'h0, 16'h0},
            8'h05, 5, 1, 8'h14, 16'h000C, 0, 8'h00, 16'h0);
    add_vec("ld_st", {ci8(6,8'h20), rr(4,0,4,6), ci8(3,8'h10), rr(4,1,4,3), rr(4,0,5,3), ci8(7,8'h30), rr(4,1,5,7), trap(8'h06)},
            8'h06, 7, 1, 8'h30, 16'hBEEF, 1, 8'h20, 16'hBEEF);
    add_vec("branch", {br(4'hF,0,8'h05), ci8(2,8'h01), ci8(3,8'h50), br(4'hE,0,8'h01), ci8(0,8'h07), br(4'hE,0,8'hFE), rr(4,1,0,3), trap(8'h08)},
            8'h08, 8, 1, 8'h50, 16'h0007, 0, 8'h00, 16'h0);
    add_vec("jr", {ci8(1,8'h05), 16'h0101, trap(8'h11), trap(8'h11), trap(8'h11), ci8(3,8'h60), rr(4,1,1,3), trap(8'h09)},
            8'h09, 4, 1, 8'h60, 16'h0005, 0, 8'h00, 16'h0);
    add_vec("ill_op0", {ci8(1,8'h03), 16'h1000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            8'hFF, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0);
    add_vec("ill_arith", {ci8(1,8'h03), 16'h7301, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            8'hFF, 1, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0);
    add_vec("ill_mem", {ci8(1,8'h03), ci8(3,8'h70), 16'h4231, rr(4,1,1,3), trap(8'h0A), 16'h0, 16'h0, 16'h0},
            8'hFF, 2, 1, 8'h70, 16'h0000, 0, 8'h00, 16'h0);
    add_vec("ill_logic", {16'h5401, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            8'hFF, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0);
    add_vec("ill_sys", {16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
            8'hFF, 0, 0, 8'h00, 16'h0000, 0, 8'h00, 16'h0);

    for (int i = 0; i < 256; i++) begin imem[i] = 16'h0; dmem[i] = 16'h0; end

    // ---- reset values and the wait-state fetch
    load_prog({ci8(1,8'h01), trap(8'h5A), 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    ack_wait = 4;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_halt_code", {24'd0, halt_code}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_pc", {16'd0, mem_addr}, 32'd0);
    do_reset();
    @(negedge clk); #1;
    chk("first_fetch_req", {31'd0, mem_req}, 32'd1);
    cnt = 0;
    stable = 1'b1;
    n = 0;
    while (n < 20) begin
      if (mem_req) begin
        cnt++;
        if (mem_addr !== 16'h0000 || !mem_ispace) stable = 1'b0;
        if (mem_ack) break;
      end
      @(negedge clk); #1;
      n++;
    end
    chk("wait_req_cycles", cnt, 32'd5);
    chk("wait_addr_stable", {31'd0, stable}, 32'd1);
    wait_halt("wait_prog");
    chk("wait_retired", retired, 32'd1);
    chk("wait_code", {24'd0, halt_code}, 32'h5A);
    ack_wait = 0;

    // ---- table-driven programs
    foreach (vt[i]) begin
      load_prog(vt[i].prog);
      pre_en   = vt[i].pre;
      pre_addr = vt[i].paddr;
      pre_data = vt[i].pdata;
      do_reset();
      wait_halt(vt[i].name);
      chk({vt[i].name, "_code"}, {24'd0, halt_code}, {24'd0, vt[i].exp_code});
      chk({vt[i].name, "_retired"}, retired, vt[i].exp_ret);
      if (vt[i].chk_en)
        chk({vt[i].name, "_data"}, {16'd0, dmem[vt[i].chk_addr]}, {16'd0, vt[i].chk_data});
    end
    pre_en = 1'b0;

    // ---- reset while a load is waiting for its ack, then a stray ack
    load_prog({ci8(3,8'h10), rr(4,0,1,3), ci8(4,8'h20), rr(4,1,1,4), trap(8'h33), 16'h0, 16'h0, 16'h0});
    pre_en = 1'b1; pre_addr = 8'h10; pre_data = 16'h1234;
    hold_data = 1'b1;
    do_reset();
    n = 0;
    while (!(mem_req && !mem_ispace) && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mid_mem_reached", {31'd0, mem_req && !mem_ispace}, 32'd1);
    chk("mid_mem_retired", retired, 32'd1);
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req_drop", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_retired", retired, 32'd0);
    chk("mid_rst_pc", {16'd0, mem_addr}, 32'd0);
    hold_data = 1'b0;
    pre_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    wait_halt("mid_rst_prog");
    chk("mid_rst_code", {24'd0, halt_code}, 32'h33);
    chk("mid_rst_final_ret", retired, 32'd4);
    chk("mid_rst_data", {16'd0, dmem[8'h20]}, 32'h1234);

    // ---- narrow core: 8-bit pc wrap and out-of-range register index
    for (int i = 0; i < 256; i++) imem[i] = 16'h0;
    imem[8'hFE] = ci8(1, 8'h21);
    imem[8'hFF] = ci8(2, 8'h30);
    imem[8'h00] = rr(4,1,1,2);
    imem[8'h01] = rr(7,0,5,1);
    imem[8'h02] = trap(8'h77);
    do_reset();
    @(negedge clk);
    reset2 = 1'b0;
    n = 0;
    while (!halt2 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("n4_halt", {31'd0, halt2}, 32'd1);
    chk("n4_code", {24'd0, halt_code2}, 32'hFF);
    chk("n4_retired", retired2, 32'd3);
    chk("n4_wrap_store", {16'd0, dmem[8'h30]}, 32'h0021);
    chk("n4_r1_kept", {16'd0, u_dut2.r_regs[1]}, 32'h0021);
    repeat (3) @(negedge clk);
    #1;
    chk("n4_halt_hold_req", {31'd0, mem_req2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
